// File: rtl/imem_loader.sv
// imem_loader: streams a program into instruction memory at run time and
// sequences the core reset around the load (hold, then release).
//
// Ports:
//   CLK, RST          clock, asynchronous active-high reset
//   start             one-cycle pulse that opens a load session
//   in_data/in_valid  word stream in; in_last marks the final word
//   in_ready          high while words are accepted
//   mem_we/mem_addr/mem_wdata  instruction memory write port
//   core_rst          processor reset, active-high
//   busy/done         session in progress / program running
//   word_count        words written this (or the last) session
//   overflow_err      sticky: program larger than memory
//   checksum          running XOR of accepted words, present only when
//                     IMEM_LOADER_CHECKSUM_EN is defined
module imem_loader #(
    parameter int DataWidth = 16,
    parameter int AddrWidth = 8,
    parameter int ResetHold = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 start,
    input  logic [DataWidth-1:0] in_data,
    input  logic                 in_valid,
    input  logic                 in_last,
    output logic                 in_ready,
    output logic                 mem_we,
    output logic [AddrWidth-1:0] mem_addr,
    output logic [DataWidth-1:0] mem_wdata,
    output logic                 core_rst,
    output logic                 busy,
    output logic                 done,
    output logic [AddrWidth:0]   word_count,
`ifdef IMEM_LOADER_CHECKSUM_EN
    output logic [DataWidth-1:0] checksum,
`endif
    output logic                 overflow_err
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        HOLD,
        RUN
    } state_t;

    localparam logic [AddrWidth-1:0] LastAddr = '1;
    localparam logic [AddrWidth:0]   Capacity = {1'b1, {AddrWidth{1'b0}}};
    localparam logic [7:0]           HoldInit = 8'(ResetHold);

    state_t               state_q, state_d;
    logic [AddrWidth-1:0] ptr_q, ptr_d;
    logic [7:0]           hold_q, hold_d;
    logic                 we_q, we_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic [DataWidth-1:0] wdata_q, wdata_d;
    logic                 core_rst_q, core_rst_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [AddrWidth:0]   count_q, count_d;
    logic                 ovf_q, ovf_d;
    logic [DataWidth-1:0] csum_q, csum_d;
    logic                 accept;

    assign accept = (state_q == LOAD) && in_valid;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        csum_d  = csum_q;

        case (state_q)
            IDLE, RUN: begin
                // A word offered alongside start is not taken: in_ready is
                // still low in this cycle.
                if (start) begin
                    state_d = LOAD;
                    ptr_d   = '0;
                    count_d = '0;
                    ovf_d   = 1'b0;
                    csum_d  = '0;
                end
            end
            LOAD: begin
                if (accept) begin
                    we_d    = 1'b1;
                    addr_d  = ptr_q;
                    wdata_d = in_data;
                    ptr_d   = ptr_q + AddrWidth'(1);
                    csum_d  = csum_q ^ in_data;
                    if (count_q != Capacity) begin
                        count_d = count_q + (AddrWidth+1)'(1);
                    end
                    if (in_last) begin
                        state_d = HOLD;
                        hold_d  = HoldInit;
                    end else if (ptr_q == LastAddr) begin
                        // Memory full with more program pending: abort
                        // and keep the core parked in reset.
                        state_d = IDLE;
                        ovf_d   = 1'b1;
                    end
                end
            end
            HOLD: begin
                // The write cycle of the last word is the first hold cycle.
                if (hold_q <= 8'd1) begin
                    hold_d  = '0;
                    state_d = RUN;
                end else begin
                    hold_d = hold_q - 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        core_rst_d = (state_d != RUN);
        busy_d     = (state_d == LOAD) || (state_d == HOLD);
        done_d     = (state_d == RUN);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            hold_q     <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            core_rst_q <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            csum_q     <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            hold_q     <= hold_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            core_rst_q <= core_rst_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            csum_q     <= csum_d;
        end
    end

    assign in_ready     = (state_q == LOAD);
    assign mem_we       = we_q;
    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;
    assign core_rst     = core_rst_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign word_count   = count_q;
    assign overflow_err = ovf_q;

`ifdef IMEM_LOADER_CHECKSUM_EN
    assign checksum = csum_q;
`else
    logic unused_csum;
    assign unused_csum = ^csum_q;
`endif

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer-side companion to the processor's instruction fetch path. Loads a program into instruction memory at run time, over a valid/ready word stream, instead of from a file at elaboration.
- Holds the core in reset while loading, writes words to consecutive addresses from 0, then releases the core after a fixed hold interval.
- Sits between a host/debug stream source and the instruction-memory write port plus the core's reset input.

Parameters:
- DataWidth, 16, instruction word width.
- AddrWidth, 8, instruction memory address width; capacity 2^AddrWidth words.
- ResetHold, 4, cycles core reset stays asserted after the last word is written; legal range 1..255.

Ports:
- CLK  input  1  system clock; all state changes on its rising edge.
- RST  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a load session.
- in_data  input  DataWidth  instruction word.
- in_valid  input  1  in_data valid.
- in_last  input  1  qualifies the accepted word as the final program word.
- in_ready  output  1  loader accepts a word this cycle.
- mem_we  output  1  instruction memory write enable.
- mem_addr  output  AddrWidth  write address.
- mem_wdata  output  DataWidth  write data.
- core_rst  output  1  reset to the processor; active-high.
- busy  output  1  high in LOAD and HOLD.
- done  output  1  high in RUN.
- word_count  output  AddrWidth+1  number of words written in the current or most recent session.
- overflow_err  output  1  sticky; the program exceeded capacity.

Behaviour:
- Reset values (async RST):
  - state = IDLE, core_rst = 1.
  - in_ready, mem_we, busy, done, overflow_err = 0.
  - mem_addr, mem_wdata, word_count = 0.
  - Hold counter = 0.
- All outputs are registered.
- in_ready is combinational from state: 1 only in LOAD.
- States:
  - IDLE: core_rst = 1. start -> LOAD; clear word_count, write pointer, overflow_err and done.
  - LOAD: a word is accepted when in_valid && in_ready.
    - On the next cycle: mem_we = 1, mem_addr = pointer, mem_wdata = word (1-cycle write latency). Pointer and word_count increment.
    - mem_we = 0 on any cycle following a non-accept.
    - Accepted word with in_last = 1 -> HOLD and load the hold counter with ResetHold.
  - HOLD: core_rst = 1; counter decrements each cycle; at 0 -> RUN.
  - RUN: core_rst = 0, done = 1. start -> LOAD; core_rst = 1 and done = 0 on the next cycle. Memory is not cleared.
- Overflow: a word accepted at pointer 2^AddrWidth-1 with in_last = 0 is still written. The next cycle enters IDLE with overflow_err = 1 and core_rst held at 1.
- A word accepted with in_last = 1 at the final address is legal and goes to HOLD.
- word_count saturates at 2^AddrWidth.
- Ignored inputs:
  - start in LOAD or HOLD.
  - in_valid outside LOAD (in_ready = 0, nothing written).
  - in_last without in_valid.
- start coincident with in_valid in IDLE: start is taken, the word is not accepted.
- RST mid-session: immediate return to reset values. core_rst reasserts asynchronously. Partially written memory contents are left as they are.
- Exactly one word is written per accept; no duplicates; addresses strictly ascending from 0.

Optional Feature:
- Macro IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - Adds output port checksum (DataWidth): running XOR of all accepted words in the session.
  - Cleared on start and on RST; updated the cycle after each accept, in step with mem_we.
  - Held through HOLD and RUN.
- Undefined: the port and logic are absent; all other behaviour is identical.

Test Plan:
- Basic load: RST 10 ns, start, then stream 0x3241, 0x5A03, 0x5C13, 0xF000 (last on the 4th), in_valid held high.
  - Required: mem_we pulses at addresses 0..3 with those data, one cycle after each accept.
  - word_count = 4.
  - core_rst falls exactly ResetHold = 4 cycles after the last write; done = 1.
- Backpressure/gaps: the same stream with in_valid toggling 1,0,1,0…
  - Required: exactly 4 writes, addresses 0..3, no writes on idle cycles.
- Overflow: AddrWidth = 2; stream 5 words, last on the 5th.
  - Required: writes at addresses 0..3; overflow_err = 1; return to IDLE; core_rst stays 1; done = 0.
- Reload: after done, pulse start and stream 0x1111 (last).
  - Required: core_rst = 1 the next cycle; a write to address 0; word_count = 1; RUN after the hold.
- Async reset mid-LOAD: assert RST between clock edges after 2 words.
  - Required: core_rst = 1, in_ready = 0, word_count = 0 immediately, without waiting for a clock edge.
- Checksum (macro defined): stream 0x00FF, 0x0F0F (last) -> checksum = 0x0FF0 once the second write completes.
